// File: rtl/hockey_pkg.sv
// Shared state and direction encodings for the DigiHockey arena core.
package hockey_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DISP   = 4'd1,
    HOLD_A = 4'd2,
    HOLD_B = 4'd3,
    SEND_A = 4'd4,
    SEND_B = 4'd5,
    RESP_A = 4'd6,
    RESP_B = 4'd7,
    GOAL_A = 4'd8,
    GOAL_B = 4'd9,
    OVER   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    DIR_STR = 2'd0,
    DIR_UP  = 2'd1,
    DIR_DN  = 2'd2
  } dir_e;

  // Raw code 3 from the player switches means straight.
  function automatic dir_e dir_decode(input logic [1:0] raw);
    case (raw)
      2'd1:    return DIR_UP;
      2'd2:    return DIR_DN;
      default: return DIR_STR;
    endcase
  endfunction

endpackage

// File: rtl/hockey_arena_if.sv
// Player inputs and display outputs of the arena, bundled for the top-level port.
interface hockey_arena_if #(
  parameter int CW = 3,
  parameter int SW = 2
);
  logic          BTNA;
  logic          BTNB;
  logic [1:0]    DIRA;
  logic [1:0]    DIRB;
  logic [CW-1:0] YA;
  logic [CW-1:0] YB;
  logic [CW-1:0] X_COORD;
  logic [CW-1:0] Y_COORD;
  logic [SW-1:0] SCORE_A;
  logic [SW-1:0] SCORE_B;
  logic [3:0]    STATE;
  logic          GAME_OVER;
  logic          WINNER;

  modport master (
    output BTNA, BTNB, DIRA, DIRB, YA, YB,
    input  X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GAME_OVER, WINNER
  );

  modport slave (
    input  BTNA, BTNB, DIRA, DIRB, YA, YB,
    output X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GAME_OVER, WINNER
  );
endinterface

// File: rtl/hockey_puck_step.sv
// One puck step: X moves one column along the heading, Y follows dir with wall bounce.
module hockey_puck_step
  import hockey_pkg::*;
#(
  parameter int CW    = 3,
  parameter int Y_MAX = 4
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  dir_e          dir_i,
  input  logic          heading_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output dir_e          dir_o
);

  localparam logic [CW-1:0] YM = CW'(Y_MAX);

  always_comb begin
    x_o   = heading_i ? x_i + CW'(1) : x_i - CW'(1);
    y_o   = y_i;
    dir_o = dir_i;
    // A single-row board has no room to bounce, so diagonals travel straight.
    if (Y_MAX > 0) begin
      case (dir_i)
        DIR_UP: begin
          if (y_i == YM) begin
            dir_o = DIR_DN;
            y_o   = y_i - CW'(1);
          end else begin
            y_o   = y_i + CW'(1);
          end
        end
        DIR_DN: begin
          if (y_i == '0) begin
            dir_o = DIR_UP;
            y_o   = y_i + CW'(1);
          end else begin
            y_o   = y_i - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hockey_arena.sv
// DigiHockey game core: serve/rally/goal/score FSM around a shared puck-step datapath.
module hockey_arena
  import hockey_pkg::*;
#(
  parameter int X_MAX     = 4,
  parameter int Y_MAX     = 4,
  parameter int CW        = 3,
  parameter int MOVE_DIV  = 1,
  parameter int DISP_CYC  = 2,
  parameter int WIN_SCORE = 3
) (
  input logic           clk,
  input logic           rst,
  hockey_arena_if.slave bus
);

  localparam int SW      = $clog2(WIN_SCORE + 1);
  localparam int CNT_MAX = (MOVE_DIV > DISP_CYC) ? MOVE_DIV : DISP_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   XM        = CW'(X_MAX);
  localparam logic [CW-1:0]   YM        = CW'(Y_MAX);
  localparam logic [CNTW-1:0] STEP_LAST = CNTW'(MOVE_DIV - 1);
  localparam logic [CNTW-1:0] DISP_LAST = CNTW'(DISP_CYC - 1);
  localparam logic [SW-1:0]   WIN       = SW'(WIN_SCORE);

  state_e          state_q, state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  dir_e            dir_q, dir_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            srv_q, srv_d;
  logic [SW-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic            win_q, win_d;
  logic            btna_q, btnb_q;

  logic            act_a, act_b;
  logic [CW-1:0]   step_x, step_y;
  dir_e            step_dir;
  logic [SW-1:0]   sa_inc, sb_inc;

  // A press only counts when its paddle row is on the board.
  assign act_a  = bus.BTNA & ~btna_q & (bus.YA <= YM);
  assign act_b  = bus.BTNB & ~btnb_q & (bus.YB <= YM);
  assign sa_inc = (sa_q == WIN) ? sa_q : sa_q + SW'(1);
  assign sb_inc = (sb_q == WIN) ? sb_q : sb_q + SW'(1);

  hockey_puck_step #(
    .CW    (CW),
    .Y_MAX (Y_MAX)
  ) u_step (
    .x_i       (x_q),
    .y_i       (y_q),
    .dir_i     (dir_q),
    .heading_i (state_q == SEND_A),
    .x_o       (step_x),
    .y_o       (step_y),
    .dir_o     (step_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_STR;
      cnt_q   <= '0;
      srv_q   <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      win_q   <= 1'b0;
      btna_q  <= 1'b0;
      btnb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      srv_q   <= srv_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      win_q   <= win_d;
      btna_q  <= bus.BTNA;
      btnb_q  <= bus.BTNB;
    end
  end

  // One counter serves as display timer, step divider and hit window;
  // every state that uses it is entered with it cleared.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    srv_d   = srv_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (bus.BTNA & ~btna_q) begin
          srv_d   = 1'b0;
          state_d = DISP;
          cnt_d   = '0;
        end else if (bus.BTNB & ~btnb_q) begin
          srv_d   = 1'b1;
          state_d = DISP;
          cnt_d   = '0;
        end
      end
      DISP: begin
        if (cnt_q == DISP_LAST) begin
          state_d = srv_q ? HOLD_B : HOLD_A;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      HOLD_A: begin
        if (act_a) begin
          x_d     = '0;
          y_d     = bus.YA;
          dir_d   = dir_decode(bus.DIRA);
          state_d = SEND_A;
          cnt_d   = '0;
        end
      end
      HOLD_B: begin
        if (act_b) begin
          x_d     = XM;
          y_d     = bus.YB;
          dir_d   = dir_decode(bus.DIRB);
          state_d = SEND_B;
          cnt_d   = '0;
        end
      end
      SEND_A, SEND_B: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          x_d   = step_x;
          y_d   = step_y;
          dir_d = step_dir;
          if (state_q == SEND_A && step_x == XM) begin
            state_d = RESP_B;
          end else if (state_q == SEND_B && step_x == '0) begin
            state_d = RESP_A;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RESP_A: begin
        if (act_a) begin
          if (bus.YA == y_q) begin
            dir_d   = dir_decode(bus.DIRA);
            state_d = SEND_A;
            cnt_d   = '0;
          end else begin
            state_d = GOAL_B;
          end
        end else if (cnt_q == STEP_LAST) begin
          state_d = GOAL_B;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      RESP_B: begin
        if (act_b) begin
          if (bus.YB == y_q) begin
            dir_d   = dir_decode(bus.DIRB);
            state_d = SEND_B;
            cnt_d   = '0;
          end else begin
            state_d = GOAL_A;
          end
        end else if (cnt_q == STEP_LAST) begin
          state_d = GOAL_A;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      GOAL_A: begin
        sa_d  = sa_inc;
        cnt_d = '0;
        if (sa_inc == WIN) begin
          state_d = OVER;
          win_d   = 1'b0;
        end else begin
          state_d = DISP;
          srv_d   = 1'b1;
        end
      end
      GOAL_B: begin
        sb_d  = sb_inc;
        cnt_d = '0;
        if (sb_inc == WIN) begin
          state_d = OVER;
          win_d   = 1'b1;
        end else begin
          state_d = DISP;
          srv_d   = 1'b0;
        end
      end
      OVER:    ;
      default: state_d = IDLE;
    endcase
  end

  assign bus.X_COORD   = x_q;
  assign bus.Y_COORD   = y_q;
  assign bus.SCORE_A   = sa_q;
  assign bus.SCORE_B   = sb_q;
  assign bus.STATE     = state_q;
  assign bus.GAME_OVER = (state_q == OVER);
  assign bus.WINNER    = win_q;

endmodule

// File: tb/tb_hockey_arena.sv
// Random play on two arenas (MOVE_DIV 1 and 3) checked each cycle against a positional game model.
module tb_hockey_arena;
  import hockey_pkg::*;

  localparam int XMX = 4;
  localparam int YMX = 4;
  localparam int DC  = 2;
  localparam int WS  = 3;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       btna [2];
  logic       btnb [2];
  logic [1:0] dira [2];
  logic [1:0] dirb [2];
  logic [2:0] ya   [2];
  logic [2:0] yb   [2];
  logic [2:0] ox   [2];
  logic [2:0] oy   [2];
  logic [1:0] osa  [2];
  logic [1:0] osb  [2];
  logic [3:0] ost  [2];
  logic       oov  [2];
  logic       own  [2];

  hockey_arena_if #(.CW(3), .SW(2)) bus0 ();
  hockey_arena_if #(.CW(3), .SW(2)) bus1 ();

  hockey_arena #(.X_MAX(XMX), .Y_MAX(YMX), .CW(3), .MOVE_DIV(1), .DISP_CYC(DC), .WIN_SCORE(WS))
    dut0 (.clk(clk), .rst(rst[0]), .bus(bus0));
  hockey_arena #(.X_MAX(XMX), .Y_MAX(YMX), .CW(3), .MOVE_DIV(3), .DISP_CYC(DC), .WIN_SCORE(WS))
    dut1 (.clk(clk), .rst(rst[1]), .bus(bus1));

  assign bus0.BTNA = btna[0];  assign bus1.BTNA = btna[1];
  assign bus0.BTNB = btnb[0];  assign bus1.BTNB = btnb[1];
  assign bus0.DIRA = dira[0];  assign bus1.DIRA = dira[1];
  assign bus0.DIRB = dirb[0];  assign bus1.DIRB = dirb[1];
  assign bus0.YA   = ya[0];    assign bus1.YA   = ya[1];
  assign bus0.YB   = yb[0];    assign bus1.YB   = yb[1];
  assign ox[0]  = bus0.X_COORD;   assign ox[1]  = bus1.X_COORD;
  assign oy[0]  = bus0.Y_COORD;   assign oy[1]  = bus1.Y_COORD;
  assign osa[0] = bus0.SCORE_A;   assign osa[1] = bus1.SCORE_A;
  assign osb[0] = bus0.SCORE_B;   assign osb[1] = bus1.SCORE_B;
  assign ost[0] = bus0.STATE;     assign ost[1] = bus1.STATE;
  assign oov[0] = bus0.GAME_OVER; assign oov[1] = bus1.GAME_OVER;
  assign own[0] = bus0.WINNER;    assign own[1] = bus1.WINNER;

  // Reference model: the puck is described by where and when the rally leg began.
  state_e ms [2];
  int mx [2], my [2], msa [2], msb [2], mwin [2], msrv [2], mt [2], mn [2];
  int mx0 [2], my0 [2], md0 [2], mhead [2];
  bit mpa [2], mpb [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  function automatic int dnorm(input logic [1:0] raw);
    return (raw == 2'd1) ? 1 : (raw == 2'd2) ? 2 : 0;
  endfunction

  // Row after k steps: unfold the walls into a triangle wave of period 2*YMX.
  function automatic int ypos(input int y0, input int d0, input int k);
    int per, p, m;
    if (d0 == 0 || YMX == 0) return y0;
    per = 2 * YMX;
    p   = (d0 == 1) ? y0 + k : y0 - k;
    m   = ((p % per) + per) % per;
    return (m <= YMX) ? m : per - m;
  endfunction

  task automatic start_leg(input int d, input int x, input int y, input int dir, input int head);
    mx[d] = x;  my[d] = y;
    mx0[d] = x; my0[d] = y; md0[d] = dir; mhead[d] = head; mn[d] = 0;
  endtask

  task automatic model_step(input int d);
    bit pa, pb, va, vb;
    int k, md;
    md = (d == 0) ? 1 : 3;
    if (rst[d]) begin
      ms[d] = IDLE; mx[d] = 0; my[d] = 0; msa[d] = 0; msb[d] = 0; mwin[d] = 0;
      msrv[d] = 0; mt[d] = 0; mn[d] = 0; mpa[d] = 0; mpb[d] = 0;
      return;
    end
    pa = btna[d] && !mpa[d];
    pb = btnb[d] && !mpb[d];
    mpa[d] = btna[d];
    mpb[d] = btnb[d];
    va = pa && (int'(ya[d]) <= YMX);
    vb = pb && (int'(yb[d]) <= YMX);
    case (ms[d])
      IDLE: begin
        if (pa)      begin msrv[d] = 0; ms[d] = DISP; mt[d] = 0; end
        else if (pb) begin msrv[d] = 1; ms[d] = DISP; mt[d] = 0; end
      end
      DISP: begin
        mt[d]++;
        if (mt[d] == DC) ms[d] = (msrv[d] == 1) ? HOLD_B : HOLD_A;
      end
      HOLD_A: if (va) begin start_leg(d, 0, int'(ya[d]), dnorm(dira[d]), 1); ms[d] = SEND_A; end
      HOLD_B: if (vb) begin start_leg(d, XMX, int'(yb[d]), dnorm(dirb[d]), 0); ms[d] = SEND_B; end
      SEND_A, SEND_B: begin
        mn[d]++;
        k = mn[d] / md;
        mx[d] = (mhead[d] == 1) ? mx0[d] + k : mx0[d] - k;
        my[d] = ypos(my0[d], md0[d], k);
        if (k == XMX) begin ms[d] = (ms[d] == SEND_A) ? RESP_B : RESP_A; mt[d] = 0; end
      end
      RESP_A: begin
        if (va) begin
          if (int'(ya[d]) == my[d]) begin start_leg(d, mx[d], my[d], dnorm(dira[d]), 1); ms[d] = SEND_A; end
          else ms[d] = GOAL_B;
        end else begin
          mt[d]++;
          if (mt[d] == md) ms[d] = GOAL_B;
        end
      end
      RESP_B: begin
        if (vb) begin
          if (int'(yb[d]) == my[d]) begin start_leg(d, mx[d], my[d], dnorm(dirb[d]), 0); ms[d] = SEND_B; end
          else ms[d] = GOAL_A;
        end else begin
          mt[d]++;
          if (mt[d] == md) ms[d] = GOAL_A;
        end
      end
      GOAL_A: begin
        if (msa[d] < WS) msa[d]++;
        mt[d] = 0;
        if (msa[d] == WS) begin ms[d] = OVER; mwin[d] = 0; end
        else begin ms[d] = DISP; msrv[d] = 1; end
      end
      GOAL_B: begin
        if (msb[d] < WS) msb[d]++;
        mt[d] = 0;
        if (msb[d] == WS) begin ms[d] = OVER; mwin[d] = 1; end
        else begin ms[d] = DISP; msrv[d] = 0; end
      end
      OVER:    mt[d]++;
      default: ;
    endcase
  endtask

  // Paddles mostly track the puck row so rallies happen; sometimes off-board rows.
  task automatic drive(input int d);
    if (ms[d] == OVER && mt[d] > 4) rst[d] = 1'b1;
    else rst[d] = ($urandom_range(0, 249) == 0);
    if ($urandom_range(0, 2) == 0) btna[d] = ~btna[d];
    if ($urandom_range(0, 2) == 0) btnb[d] = ~btnb[d];
    ya[d]   = ($urandom_range(0, 3) != 0) ? 3'(my[d]) : 3'($urandom_range(0, 7));
    yb[d]   = ($urandom_range(0, 3) != 0) ? 3'(my[d]) : 3'($urandom_range(0, 7));
    dira[d] = 2'($urandom_range(0, 3));
    dirb[d] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; btna[d] = 1'b0; btnb[d] = 1'b0;
      dira[d] = 2'd0; dirb[d] = 2'd0; ya[d] = 3'd0; yb[d] = 3'd0;
      model_step(d);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("state[%0d]", d),  int'(ost[d]), int'(ms[d]));
        check($sformatf("x[%0d]", d),      int'(ox[d]),  mx[d]);
        check($sformatf("y[%0d]", d),      int'(oy[d]),  my[d]);
        check($sformatf("score_a[%0d]", d), int'(osa[d]), msa[d]);
        check($sformatf("score_b[%0d]", d), int'(osb[d]), msb[d]);
        check($sformatf("game_over[%0d]", d), int'(oov[d]), (ms[d] == OVER) ? 1 : 0);
        check($sformatf("winner[%0d]", d), int'(own[d]), mwin[d]);
        drive(d);
        model_step(d);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
